// File: rtl/atan_addr_gen.sv
// Folds a signed complex sample to the first quadrant, block-normalises both
// magnitudes and packs them into the arctan ROM address (3-stage pipeline).
module atan_addr_gen #(
  parameter int DIN_WIDTH = 18,
  parameter int ADDR_HALF = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic [DIN_WIDTH-1:0]     din_re,
  input  logic [DIN_WIDTH-1:0]     din_im,
  input  logic                     din_valid,
  output logic [2*ADDR_HALF-1:0]   addr,
  output logic [1:0]               quad,
  output logic                     zero,
  output logic                     addr_valid
);

  localparam int MW = DIN_WIDTH - 1;
  localparam int PW = $clog2(MW);
  localparam logic [PW-1:0] P_NORM = PW'(ADDR_HALF - 1);

  // Index 0 carries the real part, index 1 the imaginary part.
  logic [1:0][DIN_WIDTH-1:0] din_c;
  logic [1:0][MW-1:0]        abs_d;
  logic [1:0][MW-1:0]        mag1_q;
  logic [1:0]                sgn1_q;
  logic                      v1_q;

  logic [MW-1:0]             max_d;
  logic [PW-1:0]             p_d;
  logic                      zero_d;
  logic [1:0][MW-1:0]        mag2_q;
  logic [PW-1:0]             p2_q;
  logic                      zero2_q;
  logic [1:0]                sgn2_q;
  logic                      v2_q;

  logic [1:0][ADDR_HALF-1:0] norm_d;
  logic [2*ADDR_HALF-1:0]    addr_d;
  logic [2*ADDR_HALF-1:0]    addr_q;
  logic [1:0]                quad_q;
  logic                      zero_q;
  logic                      valid_q;

  assign din_c[0] = din_re;
  assign din_c[1] = din_im;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [DIN_WIDTH-1:0] neg;
      logic [MW-1:0]        shifted;
      assign neg = -din_c[gi];
      // Only the most-negative input still has its MSB set after negation.
      assign abs_d[gi] = !din_c[gi][DIN_WIDTH-1] ? din_c[gi][MW-1:0] :
                         neg[DIN_WIDTH-1]        ? {MW{1'b1}}       :
                                                   neg[MW-1:0];
      assign shifted = (p2_q >= P_NORM) ? (mag2_q[gi] >> (p2_q - P_NORM))
                                        : (mag2_q[gi] << (P_NORM - p2_q));
      assign norm_d[gi] = shifted[ADDR_HALF-1:0];
    end
  endgenerate

  assign max_d = (mag1_q[0] >= mag1_q[1]) ? mag1_q[0] : mag1_q[1];

  always_comb begin
    p_d = '0;
    for (int i = 0; i < MW; i++) begin
      if (max_d[i]) p_d = PW'(i);
    end
    zero_d = (max_d == '0);
  end

  assign addr_d = zero2_q ? '0 : {norm_d[1], norm_d[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag1_q  <= '0;
      sgn1_q  <= '0;
      v1_q    <= 1'b0;
      mag2_q  <= '0;
      p2_q    <= '0;
      zero2_q <= 1'b0;
      sgn2_q  <= '0;
      v2_q    <= 1'b0;
      addr_q  <= '0;
      quad_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (ce) begin
      mag1_q  <= abs_d;
      sgn1_q  <= {din_im[DIN_WIDTH-1], din_re[DIN_WIDTH-1]};
      v1_q    <= din_valid;
      mag2_q  <= mag1_q;
      p2_q    <= p_d;
      zero2_q <= zero_d;
      sgn2_q  <= sgn1_q;
      v2_q    <= v1_q;
      addr_q  <= addr_d;
      quad_q  <= sgn2_q;
      zero_q  <= zero2_q;
      valid_q <= v2_q;
    end
  end

  assign addr       = addr_q;
  assign quad       = quad_q;
  assign zero       = zero_q;
  assign addr_valid = valid_q;

endmodule

// File: tb/tb_atan_addr_gen.sv
// Self-checking bench for atan_addr_gen: directed cases plus randomised
// streaming against an arithmetic reference model.
module tb_atan_addr_gen;
  localparam int DW   = 18;
  localparam int AH   = 9;
  localparam int MAXM = (1 << (DW - 1)) - 1;

  typedef struct {
    bit          v;
    logic [17:0] addr;
    logic [1:0]  quad;
    logic        zero;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic [DW-1:0] din_re = '0;
  logic [DW-1:0] din_im = '0;
  logic          din_valid = 1'b0;
  logic [17:0]   addr;
  logic [1:0]    quad;
  logic          zero;
  logic          addr_valid;

  int   checks = 0;
  int   errors = 0;
  rec_t hist[$];
  rec_t expo;

  always #5 clk = ~clk;

  atan_addr_gen #(.DIN_WIDTH(DW), .ADDR_HALF(AH)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
    .addr(addr), .quad(quad), .zero(zero), .addr_valid(addr_valid)
  );

  function automatic rec_t ref_calc(int re, int im, bit v);
    rec_t r;
    int ar, ai, m, p, rn, imn;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    if (ar > MAXM) ar = MAXM;
    if (ai > MAXM) ai = MAXM;
    m = (ar > ai) ? ar : ai;
    p = 0;
    for (int i = 0; i < DW - 1; i++) if (m >= (1 << i)) p = i;
    if (p >= AH - 1) begin
      rn  = ar >> (p - (AH - 1));
      imn = ai >> (p - (AH - 1));
    end else begin
      rn  = ar << ((AH - 1) - p);
      imn = ai << ((AH - 1) - p);
    end
    r.v    = v;
    r.zero = (m == 0);
    r.addr = r.zero ? 18'd0 : 18'(imn * (1 << AH) + rn);
    r.quad = {im < 0, re < 0};
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    rec_t z;
    z.v = 1'b0; z.addr = '0; z.quad = '0; z.zero = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    expo = z;
  endtask

  // One clock: drive inputs on the falling edge, update model on the rising
  // edge, compare 1 ns later.
  task automatic step(bit c, bit v, int re, int im);
    @(negedge clk);
    ce = c; din_valid = v;
    din_re = DW'(re); din_im = DW'(im);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (c) begin
      hist.push_back(ref_calc(re, im, v));
      expo = hist.pop_front();
    end
    #1;
    $display("t=%0t rst_n=%0b ce=%0b vin=%0b re=%0d im=%0d -> valid=%0b addr=%05h quad=%0b zero=%0b",
             $time, rst_n, c, v, re, im, addr_valid, addr, quad, zero);
    chk("addr_valid", 32'(addr_valid), 32'(expo.v));
    if (expo.v || !rst_n) begin
      chk("addr", 32'(addr), 32'(expo.addr));
      chk("quad", 32'(quad), 32'(expo.quad));
      chk("zero", 32'(zero), 32'(expo.zero));
    end
  endtask

  task automatic pulse_expect(string tag, int re, int im, logic [17:0] ea,
                              logic [1:0] eq, logic ez);
    step(1, 1, re, im);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk({tag, "_valid"}, 32'(addr_valid), 32'd1);
    chk({tag, "_addr"},  32'(addr), 32'(ea));
    chk({tag, "_quad"},  32'(quad), 32'(eq));
    chk({tag, "_zero"},  32'(zero), 32'(ez));
    step(1, 0, 0, 0);
  endtask

  function automatic int rand_sample();
    int s;
    s = int'($urandom) >>> (14 + $urandom_range(0, 17));
    if ($urandom_range(0, 15) == 0) s = -(1 << (DW - 1));
    return s;
  endfunction

  initial begin
    int accepted;
    bit cpat[10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    model_reset();

    // Reset held while random valid samples are driven.
    for (int i = 0; i < 4; i++) step(1, 1, rand_sample(), rand_sample());
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    rst_n = 1'b1;

    pulse_expect("eq1000", 1000, 1000, 18'h3E9F4, 2'b00, 1'b0);
    pulse_expect("small", -3, 5, 18'h280C0, 2'b01, 1'b0);
    pulse_expect("satre", -131072, 0, 18'h001FF, 2'b01, 1'b0);
    pulse_expect("satim", 0, -131072, 18'h3FE00, 2'b10, 1'b0);
    pulse_expect("zero", 0, 0, 18'h00000, 2'b00, 1'b1);
    pulse_expect("bigneg", -131071, 131071, 18'h3FFFF, 2'b01, 1'b0);

    // Streaming with ce toggling: 8 accepted samples.
    accepted = 0;
    for (int i = 0; accepted < 8; i++) begin
      step(cpat[i % 10], 1, rand_sample(), rand_sample());
      if (cpat[i % 10]) accepted++;
    end
    for (int i = 0; i < 4; i++) step(i != 1, 0, 0, 0);

    // Mid-burst asynchronous reset.
    for (int i = 0; i < 4; i++) step(1, 1, rand_sample(), rand_sample());
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid", 32'(addr_valid), 32'd0);
    chk("async_addr", 32'(addr), 32'd0);
    chk("async_quad", 32'(quad), 32'd0);
    step(1, 1, rand_sample(), rand_sample());
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, rand_sample(), rand_sample());

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           rand_sample(), rand_sample());
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
